// File: rtl/packet_framer_if.sv
// Header, payload and framed-output handshake bundle for packet_framer.
// slave is the framer's view; master is the view of whatever drives and consumes it.
interface packet_framer_if #(
    parameter int unsigned stream_w = 32
) ();
    logic [47:0]         h_addr;
    logic                h_valid;
    logic                h_ready;
    logic [stream_w-1:0] i_stream;
    logic                i_valid;
    logic                i_ready;
    logic                i_last;
    logic [stream_w-1:0] o_stream;
    logic                o_valid;
    logic                o_ready;
    logic                o_last;
    logic [stream_w-1:0] packet_length;
    logic                truncated;

    modport slave (
        input  h_addr, h_valid, i_stream, i_valid, i_last, o_ready,
        output h_ready, i_ready, o_stream, o_valid, o_last, packet_length, truncated
    );

    modport master (
        output h_addr, h_valid, i_stream, i_valid, i_last, o_ready,
        input  h_ready, i_ready, o_stream, o_valid, o_last, packet_length, truncated
    );
endinterface

// File: rtl/packet_framer.sv
// Prepends a two-word destination-address header to a payload stream and reports framed length.
// Define PACKET_FRAMER_TRUNCATE_EN to cap packets at max_packet_length words and drain the excess.
module packet_framer #(
    parameter int unsigned max_packet_length = 256,
    parameter int unsigned stream_w          = 32
) (
    input  logic           clk,
    input  logic           rst,
    packet_framer_if.slave bus
);
    localparam int unsigned       WCNT_W   = $clog2(max_packet_length) + 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAYLOAD, DRAIN} state_t;

    state_t              state;
    logic [47:0]         addr;
    logic [WCNT_W-1:0]   wcnt;
    logic [stream_w-1:0] packet_length;

    logic                h_ready;
    logic                i_ready;
    logic                o_valid;
    logic                o_last;
    logic [stream_w-1:0] o_stream;
    logic                at_limit;
    logic                h_hs;
    logic                i_hs;
    logic                o_hs;

`ifdef PACKET_FRAMER_TRUNCATE_EN
    logic truncated;

    // The word on the output is the last one that still fits in the packet.
    assign at_limit = (wcnt == WCNT_W'(max_packet_length - 1));

    always_ff @(posedge clk) begin
        if (rst) truncated <= 1'b0;
        else     truncated <= (state == PAYLOAD) && i_hs && !bus.i_last && at_limit;
    end

    assign bus.truncated = truncated;
`else
    assign at_limit      = 1'b0;
    assign bus.truncated = 1'b0;
`endif

    // Output muxing: header words come from the address register, payload passes straight through.
    always_comb begin
        h_ready  = 1'b0;
        i_ready  = 1'b0;
        o_valid  = 1'b0;
        o_last   = 1'b0;
        o_stream = '0;
        case (state)
            IDLE: h_ready = 1'b1;
            HDR0: begin
                o_valid  = 1'b1;
                o_stream = stream_w'(addr[47:16]);
            end
            HDR1: begin
                o_valid  = 1'b1;
                o_stream = stream_w'(addr[15:0]);
            end
            PAYLOAD: begin
                o_stream = bus.i_stream;
                o_valid  = bus.i_valid;
                i_ready  = bus.o_ready;
                o_last   = bus.i_last | at_limit;
            end
            DRAIN: i_ready = 1'b1;
            default: ;
        endcase
    end

    assign h_hs = bus.h_valid & h_ready;
    assign i_hs = bus.i_valid & i_ready;
    assign o_hs = o_valid & bus.o_ready;

    // wcnt is the zero-based index of the word currently on the output, so wcnt+1 is the length so far.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            wcnt          <= '0;
            packet_length <= '0;
        end else begin
            if (o_hs && (wcnt != WCNT_MAX)) wcnt <= wcnt + WCNT_W'(1);
            if (o_hs && o_last) packet_length <= stream_w'(wcnt) + stream_w'(1);
            case (state)
                IDLE: begin
                    if (h_hs) begin
                        addr  <= bus.h_addr;
                        wcnt  <= '0;
                        state <= HDR0;
                    end
                end
                HDR0: if (o_hs) state <= HDR1;
                HDR1: if (o_hs) state <= PAYLOAD;
                PAYLOAD: begin
                    if (i_hs) begin
                        if (bus.i_last)    state <= IDLE;
                        else if (at_limit) state <= DRAIN;
                    end
                end
                DRAIN: if (i_hs && bus.i_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.h_ready       = h_ready;
    assign bus.i_ready       = i_ready;
    assign bus.o_valid       = o_valid;
    assign bus.o_last        = o_last;
    assign bus.o_stream      = o_stream;
    assign bus.packet_length = packet_length;
endmodule

// File: tb/tb_packet_framer.sv
// Randomized bench for packet_framer: a queue-based model of framed packets checks every output beat.
module tb_packet_framer;
    localparam int SW = 32;
`ifdef PACKET_FRAMER_TRUNCATE_EN
    localparam int MAXLEN = 8;
    localparam bit TRUNC  = 1'b1;
`else
    localparam int MAXLEN = 256;
    localparam bit TRUNC  = 1'b0;
`endif

    typedef struct packed {
        logic [SW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packet_framer_if #(.stream_w(SW)) bus ();

    packet_framer #(
        .max_packet_length(MAXLEN),
        .stream_w         (SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [47:0] hdr_q[$];
    beat_t       pay_q[$];
    beat_t       exp_q[$];
    int          len_q[$];
    bit          cut_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    bit busy, draining, len_check, exp_cut, expect_idle;
    int hdr_left, exp_len, pay_beats;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected framing: two address words, then payload, capped at MAXLEN words when truncation is built in.
    task automatic add_packet(input logic [47:0] a, input int n);
        int keep;
        bit cut;
        logic [SW-1:0] d;
        keep = n;
        cut  = 1'b0;
        if (TRUNC && (n > MAXLEN - 2)) begin
            keep = MAXLEN - 2;
            cut  = 1'b1;
        end
        hdr_q.push_back(a);
        exp_q.push_back(beat_t'{data: SW'(a >> 16), last: 1'b0});
        exp_q.push_back(beat_t'{data: SW'(a & 48'hFFFF), last: 1'b0});
        for (int i = 0; i < n; i++) begin
            d = $urandom();
            pay_q.push_back(beat_t'{data: d, last: (i == n - 1)});
            if (i < keep) exp_q.push_back(beat_t'{data: d, last: (i == keep - 1)});
        end
        len_q.push_back(2 + keep);
        cut_q.push_back(cut);
    endtask

    function automatic logic [47:0] rand_addr();
        return 48'({$urandom(), $urandom()});
    endfunction

    // mode 0: always ready/valid; 1: o_ready toggles, gapped inputs; 2: fully random.
    task automatic cycle(input int mode);
        beat_t b;
        @(posedge clk);
        #1;
        if (hdr_q.size() > 0 && (mode == 0 || $urandom_range(0, 3) != 0)) begin
            bus.h_valid = 1'b1;
            bus.h_addr  = hdr_q[0];
        end else begin
            bus.h_valid = 1'b0;
            bus.h_addr  = rand_addr();
        end
        if (pay_q.size() > 0 && (mode == 0 || $urandom_range(0, 2) != 0)) begin
            bus.i_valid  = 1'b1;
            bus.i_stream = pay_q[0].data;
            bus.i_last   = pay_q[0].last;
        end else begin
            bus.i_valid  = 1'b0;
            bus.i_stream = $urandom();
            bus.i_last   = 1'($urandom_range(0, 1));
        end
        case (mode)
            0:       bus.o_ready = 1'b1;
            1:       bus.o_ready = ~bus.o_ready;
            default: bus.o_ready = 1'($urandom_range(0, 1));
        endcase
        #3;

        if (expect_idle) begin
            chk("h_ready_after_last", 64'(bus.h_ready), 64'(1));
            expect_idle = 1'b0;
        end
        if (len_check) begin
            chk("packet_length", 64'(bus.packet_length), 64'(exp_len));
            chk("truncated_pulse", 64'(bus.truncated), 64'(exp_cut));
            len_check = 1'b0;
        end else begin
            chk("truncated_quiet", 64'(bus.truncated), 64'(0));
        end

        if (!busy) begin
            chk("idle_h_ready", 64'(bus.h_ready), 64'(1));
            chk("idle_o_valid", 64'(bus.o_valid), 64'(0));
            chk("idle_i_ready", 64'(bus.i_ready), 64'(0));
        end else begin
            chk("busy_h_ready", 64'(bus.h_ready), 64'(0));
            if (hdr_left > 0) begin
                chk("hdr_i_ready", 64'(bus.i_ready), 64'(0));
                chk("hdr_o_valid", 64'(bus.o_valid), 64'(1));
                chk("hdr_o_last", 64'(bus.o_last), 64'(0));
                if (exp_q.size() > 0) chk("hdr_word_stable", 64'(bus.o_stream), 64'(exp_q[0].data));
            end else if (draining) begin
                chk("drain_i_ready", 64'(bus.i_ready), 64'(1));
                chk("drain_o_valid", 64'(bus.o_valid), 64'(0));
            end else begin
                chk("pay_i_ready", 64'(bus.i_ready), 64'(bus.o_ready));
                chk("pay_o_valid", 64'(bus.o_valid), 64'(bus.i_valid));
            end
        end

        if (bus.o_valid && bus.o_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_o_hs", 64'(bus.o_valid), 64'(0));
            end else begin
                b = exp_q.pop_front();
                chk("o_stream", 64'(bus.o_stream), 64'(b.data));
                chk("o_last", 64'(bus.o_last), 64'(b.last));
                if (hdr_left > 0) hdr_left--;
                if (b.last) begin
                    len_check = 1'b1;
                    exp_len   = len_q.pop_front();
                    exp_cut   = cut_q.pop_front();
                    if (exp_cut) draining = 1'b1;
                end
            end
        end
        if (bus.i_valid && bus.i_ready) begin
            b = pay_q.pop_front();
            pay_beats++;
            if (b.last) begin
                busy        = 1'b0;
                draining    = 1'b0;
                expect_idle = 1'b1;
            end
        end
        if (bus.h_valid && bus.h_ready) begin
            void'(hdr_q.pop_front());
            busy      = 1'b1;
            hdr_left  = 2;
            pay_beats = 0;
        end
    endtask

    task automatic run(input int mode, input int stop_beats, input int budget);
        int c;
        c = 0;
        while ((hdr_q.size() > 0 || pay_q.size() > 0 || exp_q.size() > 0 || len_check || expect_idle)
               && c < budget) begin
            if (stop_beats > 0 && busy && hdr_left == 0 && pay_beats >= stop_beats) break;
            cycle(mode);
            c++;
        end
        if (stop_beats > 0) chk("reached_stop_beat", 64'(pay_beats), 64'(stop_beats));
        else chk("run_drained", 64'(hdr_q.size() + pay_q.size() + exp_q.size()), 64'(0));
    endtask

    initial begin
        bus.h_valid  = 1'b0;
        bus.h_addr   = '0;
        bus.i_valid  = 1'b0;
        bus.i_stream = '0;
        bus.i_last   = 1'b0;
        bus.o_ready  = 1'b0;
        busy = 1'b0; draining = 1'b0; len_check = 1'b0; exp_cut = 1'b0; expect_idle = 1'b0;
        hdr_left = 0; exp_len = 0; pay_beats = 0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #3;
        chk("rst_h_ready", 64'(bus.h_ready), 64'(1));
        chk("rst_o_valid", 64'(bus.o_valid), 64'(0));
        chk("rst_o_last", 64'(bus.o_last), 64'(0));
        chk("rst_i_ready", 64'(bus.i_ready), 64'(0));
        chk("rst_packet_length", 64'(bus.packet_length), 64'(0));
        chk("rst_truncated", 64'(bus.truncated), 64'(0));
        chk("rst_o_stream", 64'(bus.o_stream), 64'(0));

        add_packet(48'h0011_2233_4455, 3);
        run(0, 0, 100);

        add_packet(48'h0011_2233_4455, 3);
        run(1, 0, 200);

        add_packet(rand_addr(), 1);
        add_packet(rand_addr(), 1);
        run(0, 0, 100);

        add_packet(rand_addr(), 10);
        add_packet(rand_addr(), 2);
        run(0, 0, 200);

        repeat (25) add_packet(rand_addr(), $urandom_range(1, 12));
        run(2, 0, 4000);

        // Abandon a packet mid-payload with reset, then frame a fresh one.
        add_packet(rand_addr(), 5);
        run(0, 2, 100);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.h_valid = 1'b0;
        bus.i_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #3;
        chk("midrst_o_valid", 64'(bus.o_valid), 64'(0));
        chk("midrst_h_ready", 64'(bus.h_ready), 64'(1));
        chk("midrst_packet_length", 64'(bus.packet_length), 64'(0));
        hdr_q.delete(); pay_q.delete(); exp_q.delete(); len_q.delete(); cut_q.delete();
        busy = 1'b0; draining = 1'b0; len_check = 1'b0; expect_idle = 1'b0; hdr_left = 0;

        add_packet(rand_addr(), 3);
        run(1, 0, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
